cp0_intc: RTL and testbench
===========================

// Module: cp0_intc
// PURPOSE
//  Parametrised coprocessor-0 successor: SR/Cause/EPC/PRId plus an optional Count/Compare timer.
//  Supports a configurable number of hardware interrupt lines, with masking, exception/interrupt arbitration and EPC capture.
//  Sits beside the W stage; its req output flushes the pipeline and redirects the NPC to the handler.
//  epc_out feeds the NPC for eret.
// PARAMETERS
//  NUM_HWINT  6             hardware interrupt lines, legal 1..6; mapped to SR/Cause bits [10 +: NUM_HWINT]
//  PRID_VAL   32'h2002_0907 read-only PRId value
//  SR_RST     32'h0000_0000 SR value at reset
// PORTS
//  clk            in   1          rising-edge clock
//  reset_n        in   1          asynchronous active-low reset
//  rd_addr        in   5          CP0 read index (mfc0)
//  wr_addr        in   5          CP0 write index (mtc0)
//  wr_data        in   32         mtc0 write data
//  wr_en          in   1          mtc0 write enable
//  pc             in   32         PC of the W-stage instruction
//  in_delay_slot  in   1          W-stage instruction is in a branch delay slot
//  exc_code_in    in   5          exception code; 0 = no exception
//  hw_int         in   NUM_HWINT  level-sensitive device interrupts
//  eret           in   1          clear SR.EXL
//  req            out  1          take exception/interrupt this cycle (combinational)
//  epc_out        out  32         EPC to NPC; shows the capture value while req=1
//  rd_data        out  32         mfc0 read data (combinational)
// BEHAVIOUR
//  Register indices: 9 Count, 11 Compare, 12 SR, 13 Cause, 14 EPC, 15 PRId. Any other index reads 0.
//  SR fields: IM = SR[10 +: NUM_HWINT], EXL = SR[1], IE = SR[0].
//  Cause fields: BD = [31], TI = [30], IP = [10 +: NUM_HWINT], ExcCode = [6:2].
//  Effective lines: line = hw_int, with bit NUM_HWINT-1 ORed with TI.
//  int_req = !EXL & IE & |(line & IM).
//  exc_req = !EXL & (exc_code_in != 0).
//  req = int_req | exc_req.
//  Arbitration: an interrupt outranks an exception; on int_req, ExcCode <= 0, otherwise ExcCode <= exc_code_in.
//  On req (one edge):
//   - EXL <= 1
//   - BD <= in_delay_slot
//   - EPC <= in_delay_slot ? pc-4 : pc (32-bit modular)
//  epc_out = req ? capture value : EPC.
//  Cause.IP <= line every cycle, unconditionally.
//  Cause is read-only to mtc0. Writes to PRId and to unmapped indices are dropped.
//  mtc0 writes SR (12) or EPC (14) on the next edge only when req=0; req suppresses the write.
//  eret sets EXL <= 0, but req in the same cycle wins and EXL stays 1.
//  rd_data for EPC returns epc_out, so the same-cycle capture value is visible.
//  Reset (async, while reset_n=0):
//   - SR = SR_RST, Cause = 0, EPC = 0
//   - Count = 0, Compare = 32'hFFFF_FFFF
//   - req = 0 whenever exc_code_in = 0
//  Reset asserted mid-capture discards the pending capture. Release is synchronous to clk.
//  Exactly one of these three per edge: capture, mtc0 write, or nothing (eret may accompany any of them).
// CONFIGURATION
//  CP0_TIMER_EN defined:
//   - Count increments by 1 every cycle and wraps 32'hFFFF_FFFF -> 0.
//   - mtc0 to Count loads wr_data; that edge performs no increment.
//   - When Count == Compare, TI <= 1 (sticky).
//   - mtc0 to Compare loads it and clears TI. Clear wins over a same-edge set.
//  CP0_TIMER_EN undefined: no Count/Compare storage; indices 9/11 read 0 and ignore writes; TI is constant 0.
// STRUCTURE
//  Package cp0_pkg: register-index localparams, SR/Cause field bit positions, ExcCode constants (INT = 0, etc.).
//  Sub-module cp0_timer (Count, Compare, TI) is instantiated only under CP0_TIMER_EN.
//  Top level holds SR/Cause/EPC, arbitration and the read mux.
// TESTING
//  1. SR = 32'h0000_0401, hw_int[0] = 1 -> same-cycle req = 1; next edge: ExcCode = 0, EXL = 1, EPC = pc.
//  2. exc_code_in = 5'd10, in_delay_slot = 1, pc = 32'h3008 -> req = 1; EPC = 32'h3004, BD = 1, ExcCode = 10.
//  3. EXL = 1, then hw_int/exc asserted -> req = 0. eret with no other request -> EXL = 0; a pending masked-in line then raises req.
//  4. mtc0 SR with wr_en = 1 in the same cycle as req = 1 -> SR keeps EXL = 1 and the write is dropped. eret + req -> EXL = 1.
//  5. CP0_TIMER_EN: Count loaded 32'hFFFF_FFFE, Compare = 32'h0 -> Count wraps to 0, then TI = 1. With SR = 32'h0000_8001 this gives req with ExcCode = 0. Writing Compare clears TI.
//  6. reset_n pulsed low mid-run -> all registers return to reset values immediately, without a clock edge.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, SR/Cause field positions and exception codes.
// Count/Compare logic elsewhere is present only when CP0_TIMER_EN is defined.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int IM_LSB    = 10;
  localparam int CAUSE_BD  = 31;
  localparam int CAUSE_TI  = 30;
  localparam int EXC_LSB   = 2;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_CPU  = 5'd11,
    EXC_OV   = 5'd12
  } exc_code_e;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with sticky timer-interrupt flag; instantiated by cp0_intc
// only when CP0_TIMER_EN is defined.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wr_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  // A Count load replaces that edge's increment; the adder wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      count <= '0;
    else if (count_we) count <= wr_data;
    else               count <= count + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        compare <= COMPARE_RST;
    else if (compare_we) compare <= wr_data;
  end

  // Writing Compare acknowledges the interrupt and beats a coincident match.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                ti <= 1'b0;
    else if (compare_we)         ti <= 1'b0;
    else if (count == compare)   ti <= 1'b1;
  end

endmodule

// File: rtl/cp0_intc.sv
// Coprocessor-0 interrupt/exception controller: SR, Cause, EPC, PRId and read mux.
// Define CP0_TIMER_EN to add the Count/Compare timer (cp0_timer) and its TI interrupt.
module cp0_intc
  import cp0_pkg::*;
#(
  parameter int          NUM_HWINT = 6,
  parameter logic [31:0] PRID_VAL  = 32'h2002_0907,
  parameter logic [31:0] SR_RST    = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [4:0]           rd_addr,
  input  logic [4:0]           wr_addr,
  input  logic [31:0]          wr_data,
  input  logic                 wr_en,
  input  logic [31:0]          pc,
  input  logic                 in_delay_slot,
  input  logic [4:0]           exc_code_in,
  input  logic [NUM_HWINT-1:0] hw_int,
  input  logic                 eret,
  output logic                 req,
  output logic [31:0]          epc_out,
  output logic [31:0]          rd_data
);

  logic [31:0]          sr_q, sr_d;
  logic [31:0]          epc_q;
  logic                 bd_q;
  logic [NUM_HWINT-1:0] ip_q;
  logic [4:0]           exc_code_q;
  logic [NUM_HWINT-1:0] line;
  logic [NUM_HWINT-1:0] im;
  logic                 exl, ie;
  logic                 int_req, exc_req;
  logic                 wr_ok;
  logic [31:0]          epc_capture;
  logic [31:0]          cause_rd;
  logic                 ti;

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;

  cp0_timer u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .count_we   (wr_ok && (wr_addr == REG_COUNT)),
    .compare_we (wr_ok && (wr_addr == REG_COMPARE)),
    .wr_data    (wr_data),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );
`else
  assign ti = 1'b0;
`endif

  // The timer shares the top hardware line.
  always_comb begin
    line                = hw_int;
    line[NUM_HWINT-1]   = hw_int[NUM_HWINT-1] | ti;
  end

  assign im  = sr_q[IM_LSB +: NUM_HWINT];
  assign exl = sr_q[SR_EXL];
  assign ie  = sr_q[SR_IE];

  // req is a one-cycle take strobe with no handshake: the pipeline must flush
  // on the same cycle it is high; the capture happens on the following edge.
  // Interrupts are held off during reset so only a live exception can raise req.
  assign int_req = reset_n & ~exl & ie & (|(line & im));
  assign exc_req = ~exl & (exc_code_in != 5'd0);
  assign req     = int_req | exc_req;
  assign wr_ok   = wr_en & ~req;

  assign epc_capture = in_delay_slot ? (pc - 32'd4) : pc;
  assign epc_out     = req ? epc_capture : epc_q;

  // Capture outranks mtc0; eret clears EXL unless a capture sets it again.
  always_comb begin
    sr_d = sr_q;
    if (req) begin
      sr_d[SR_EXL] = 1'b1;
    end else begin
      if (wr_ok && (wr_addr == REG_SR)) sr_d = wr_data;
      if (eret) sr_d[SR_EXL] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sr_q <= SR_RST;
    else          sr_q <= sr_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        epc_q <= '0;
    else if (req)                        epc_q <= epc_capture;
    else if (wr_ok && (wr_addr == REG_EPC)) epc_q <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bd_q       <= 1'b0;
      exc_code_q <= EXC_INT;
      ip_q       <= '0;
    end else begin
      ip_q <= line;
      if (req) begin
        bd_q       <= in_delay_slot;
        exc_code_q <= int_req ? EXC_INT : exc_code_in;
      end
    end
  end

  always_comb begin
    cause_rd                        = '0;
    cause_rd[CAUSE_BD]              = bd_q;
    cause_rd[CAUSE_TI]              = ti;
    cause_rd[IM_LSB +: NUM_HWINT]   = ip_q;
    cause_rd[EXC_LSB +: 5]          = exc_code_q;
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
`ifdef CP0_TIMER_EN
      REG_COUNT:   rd_data = count;
      REG_COMPARE: rd_data = compare;
`endif
      REG_SR:      rd_data = sr_q;
      REG_CAUSE:   rd_data = cause_rd;
      REG_EPC:     rd_data = epc_out;
      REG_PRID:    rd_data = PRID_VAL;
      default:     rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_intc.sv
// Directed bench for cp0_intc with a queued scoreboard; timer vectors run when CP0_TIMER_EN is defined.
module tb_cp0_intc;

  localparam int K_REQ = 0;
  localparam int K_EPC = 1;
  localparam int K_RD  = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  rd_addr;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [31:0] pc;
  logic        in_delay_slot;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        eret;
  logic        req;
  logic [31:0] epc_out;
  logic [31:0] rd_data;

  logic [31:0] exp_q[$];
  int          kind_q[$];
  logic [4:0]  addr_q[$];
  string       name_q[$];

  int total = 0;
  int bad   = 0;

  cp0_intc dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rd_addr       (rd_addr),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .pc            (pc),
    .in_delay_slot (in_delay_slot),
    .exc_code_in   (exc_code_in),
    .hw_int        (hw_int),
    .eret          (eret),
    .req           (req),
    .epc_out       (epc_out),
    .rd_data       (rd_data)
  );

  // clock / reset
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    bad = bad + 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // scoreboard monitor: drains expectations at each falling edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [31:0] act;
      logic [31:0] e;
      int          k;
      logic [4:0]  a;
      string       n;
      e = exp_q.pop_front();
      k = kind_q.pop_front();
      a = addr_q.pop_front();
      n = name_q.pop_front();
      if (k == K_RD) rd_addr = a;
      #1;
      case (k)
        K_REQ:   act = {31'd0, req};
        K_EPC:   act = epc_out;
        default: act = rd_data;
      endcase
      total = total + 1;
      if (act !== e) begin
        bad = bad + 1;
        $display("FAIL %s: actual=%h required=%h", n, act, e);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en         = 1'b0;
    exc_code_in   = 5'd0;
    eret          = 1'b0;
    hw_int        = 6'd0;
    in_delay_slot = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic chk(input int k, input logic [4:0] a, input logic [31:0] e, input string n);
    exp_q.push_back(e);
    kind_q.push_back(k);
    addr_q.push_back(a);
    name_q.push_back(n);
  endtask

  initial begin
    reset_n = 1'b0;
    rd_addr = 5'd0;
    wr_addr = 5'd0;
    wr_data = 32'd0;
    pc      = 32'd0;
    idle();
    #1;
    chk(K_RD, 5'd12, 32'h0, "rst_sr");
    chk(K_RD, 5'd13, 32'h0, "rst_cause");
    chk(K_RD, 5'd14, 32'h0, "rst_epc");
    chk(K_RD, 5'd15, 32'h2002_0907, "rst_prid");
    chk(K_REQ, 5'd0, 32'h0, "rst_req");
`ifdef CP0_TIMER_EN
    chk(K_RD, 5'd9, 32'h0, "rst_count");
    chk(K_RD, 5'd11, 32'hFFFF_FFFF, "rst_compare");
`endif
    step();
    reset_n = 1'b1;
    step();

    // interrupt take
    mtc0(5'd12, 32'h0000_0401);
    pc = 32'h1000; hw_int = 6'h01;
    chk(K_REQ, 0, 32'h1, "int_req");
    chk(K_EPC, 0, 32'h1000, "int_epc_out");
    chk(K_RD, 5'd14, 32'h1000, "int_epc_rd");
    step();
    idle();
    chk(K_RD, 5'd13, 32'h0000_0400, "int_cause");
    chk(K_RD, 5'd12, 32'h0000_0403, "int_sr_exl");
    chk(K_RD, 5'd14, 32'h1000, "int_epc_held");
    chk(K_REQ, 0, 32'h0, "int_req_after");
    step();

    // EXL blocks requests; eret reopens
    hw_int = 6'h01; exc_code_in = 5'd5;
    chk(K_REQ, 0, 32'h0, "exl_block");
    step();
    exc_code_in = 5'd0; eret = 1'b1;
    chk(K_REQ, 0, 32'h0, "eret_cycle_req");
    step();
    eret = 1'b0; pc = 32'h2000;
    chk(K_REQ, 0, 32'h1, "pending_after_eret");
    chk(K_RD, 5'd12, 32'h0000_0401, "sr_after_eret");
    chk(K_EPC, 0, 32'h2000, "pending_epc_out");
    step();
    idle(); eret = 1'b1;
    step();

    // mtc0 SR suppressed by req
    idle(); exc_code_in = 5'd8; pc = 32'h2100;
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0;
    chk(K_REQ, 0, 32'h1, "wr_vs_req");
    step();
    idle();
    chk(K_RD, 5'd12, 32'h0000_0403, "sr_write_dropped");
    chk(K_RD, 5'd13, 32'h0000_0020, "cause_exc8");
    chk(K_RD, 5'd14, 32'h2100, "epc_exc8");
    eret = 1'b1;
    step();

    // eret with req: EXL stays set
    idle(); exc_code_in = 5'd12; eret = 1'b1; pc = 32'h2200;
    chk(K_REQ, 0, 32'h1, "eret_req");
    step();
    idle();
    chk(K_RD, 5'd12, 32'h0000_0403, "eret_loses");
    chk(K_RD, 5'd13, 32'h0000_0030, "cause_exc12");
    chk(K_RD, 5'd14, 32'h2200, "epc_exc12");
    step();

    // mtc0 EPC while no req
    mtc0(5'd14, 32'h5555_0000);
    chk(K_RD, 5'd14, 32'h5555_0000, "epc_write");
    eret = 1'b1;
    step();
    idle();
    chk(K_RD, 5'd12, 32'h0000_0401, "eret_alone");

    // delay-slot exception
    exc_code_in = 5'd10; in_delay_slot = 1'b1; pc = 32'h3008;
    chk(K_REQ, 0, 32'h1, "ds_req");
    chk(K_EPC, 0, 32'h3004, "ds_epc_out");
    chk(K_RD, 5'd14, 32'h3004, "ds_epc_rd");
    step();
    idle();
    chk(K_RD, 5'd13, 32'h8000_0028, "ds_cause");
    chk(K_RD, 5'd14, 32'h3004, "ds_epc");
    eret = 1'b1;
    step();

    // interrupt outranks exception
    idle(); exc_code_in = 5'd4; hw_int = 6'h01; pc = 32'h4000;
    chk(K_REQ, 0, 32'h1, "arb_req");
    step();
    idle();
    chk(K_RD, 5'd13, 32'h0000_0400, "arb_cause");
    chk(K_RD, 5'd14, 32'h4000, "arb_epc");
    eret = 1'b1;
    step();
    idle();

    // masking
    mtc0(5'd12, 32'h0000_0001);
    hw_int = 6'h3F;
    chk(K_REQ, 0, 32'h0, "masked");
    step();
    idle();
    mtc0(5'd12, 32'h0000_8001);
    hw_int = 6'h20;
    chk(K_REQ, 0, 32'h1, "top_line_req");
    chk(K_RD, 5'd12, 32'h0000_8001, "sr_8001");
    step();
    idle();
    chk(K_RD, 5'd13, 32'h0000_8000, "top_line_cause");
    eret = 1'b1;
    step();
    idle();

    // read-only / unmapped
    mtc0(5'd13, 32'hFFFF_FFFF);
    chk(K_RD, 5'd13, 32'h0, "cause_ro");
    mtc0(5'd15, 32'h0);
    chk(K_RD, 5'd15, 32'h2002_0907, "prid_ro");
    mtc0(5'd3, 32'h1234);
    chk(K_RD, 5'd3, 32'h0, "unmapped");

`ifdef CP0_TIMER_EN
    mtc0(5'd11, 32'h0);
    mtc0(5'd9, 32'hFFFF_FFFE);
    chk(K_RD, 5'd9, 32'hFFFF_FFFE, "count_load");
    chk(K_REQ, 0, 32'h0, "tmr_no_req0");
    step();
    chk(K_RD, 5'd9, 32'hFFFF_FFFF, "count_max");
    step();
    chk(K_RD, 5'd9, 32'h0, "count_wrap");
    chk(K_REQ, 0, 32'h0, "tmr_no_req1");
    step();
    chk(K_RD, 5'd9, 32'h1, "count_after_match");
    chk(K_REQ, 0, 32'h1, "ti_req");
    step();
    chk(K_RD, 5'd13, 32'h4000_8000, "ti_cause");
    mtc0(5'd11, 32'h100);
    chk(K_RD, 5'd13, 32'h0000_8000, "ti_cleared");
    chk(K_RD, 5'd11, 32'h100, "compare_rd");
    eret = 1'b1;
    step();
    idle();
`else
    mtc0(5'd9, 32'h77);
    mtc0(5'd11, 32'h77);
    chk(K_RD, 5'd9, 32'h0, "no_count");
    chk(K_RD, 5'd11, 32'h0, "no_compare");
    step();
`endif

    // async reset mid-run
    mtc0(5'd12, 32'h0000_0403);
    mtc0(5'd14, 32'hABCD_0000);
    reset_n = 1'b0;
    chk(K_RD, 5'd12, 32'h0, "arst_sr");
    chk(K_RD, 5'd13, 32'h0, "arst_cause");
    chk(K_RD, 5'd14, 32'h0, "arst_epc");
    chk(K_REQ, 0, 32'h0, "arst_req");
`ifdef CP0_TIMER_EN
    chk(K_RD, 5'd9, 32'h0, "arst_count");
    chk(K_RD, 5'd11, 32'hFFFF_FFFF, "arst_compare");
`endif
    step();
    reset_n = 1'b1;
    step();
    chk(K_RD, 5'd12, 32'h0, "post_rst_sr");
    step();
    step();

    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
